// File: rtl/router_fsm_nch.sv
// router_fsm_nch: control FSM for a 1xN packet router.
// Decodes the header address, waits for the destination FIFO to drain
// (with an optional timeout), sequences header/payload/parity loading,
// handles FIFO-full stalls and drops packets with an out-of-range address.
// Optional feature macro: ROUTER_FSM_DROP_STATS_EN adds a saturating
// drop counter (drop_count) with a synchronous clear (clr_stats).
//
// state              | meaning
// -------------------+---------------------------------------------------
// ST_DECODE          | idle / header decode, latch destination channel
// ST_WAIT            | destination FIFO not empty, wait (with timeout)
// ST_LFD             | load header byte into FIFO
// ST_LD              | load payload bytes
// ST_FULL            | destination FIFO full, stall
// ST_LAF             | resume loading after a full stall
// ST_LP              | load parity byte
// ST_CPE             | check parity, clear internal registers
// ST_DROP            | discard packet (bad address or wait timeout)

module router_fsm_nch #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 1023,
    parameter int TO_W         = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              write_enb_reg,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop_state,
    output logic [ADDR_W-1:0] sel_ch,
    output logic              timeout_err
`ifdef ROUTER_FSM_DROP_STATS_EN
    ,
    input  logic              clr_stats,
    output logic [15:0]       drop_count
`endif
);

    typedef enum logic [3:0] {
        ST_DECODE = 4'd0,
        ST_WAIT   = 4'd1,
        ST_LFD    = 4'd2,
        ST_LD     = 4'd3,
        ST_FULL   = 4'd4,
        ST_LAF    = 4'd5,
        ST_LP     = 4'd6,
        ST_CPE    = 4'd7,
        ST_DROP   = 4'd8
    } state_t;

    // Per-channel flags are padded to the full address space so that any
    // address value can index them; unused channels read as 0.
    localparam int PAD_W = 1 << ADDR_W;

    // Timeout runs as a down-counter loaded on every cycle outside
    // ST_WAIT; terminal count 0 marks the WAIT_TIMEOUT-th cycle in ST_WAIT.
    localparam bit             TO_EN   = (WAIT_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sel_ch_q, sel_ch_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              timeout_fire;

    logic [PAD_W-1:0]  empty_pad;
    logic [PAD_W-1:0]  srst_pad;
    logic              addr_valid;
    logic              srst_hit;

    // Pad per-channel flags out to the address space and decode the header
    always_comb begin
        empty_pad                = '0;
        empty_pad[NUM_CH-1:0]    = fifo_empty;
        srst_pad                 = '0;
        srst_pad[NUM_CH-1:0]     = soft_reset;
        addr_valid               = (int'(data_in) < NUM_CH);
        srst_hit                 = srst_pad[sel_ch_q];
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_DECODE;
            sel_ch_q      <= '0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_ch_q      <= sel_ch_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; a soft reset on the selected channel overrides all
    always_comb begin
        state_d      = state_q;
        timeout_fire = 1'b0;
        case (state_q)
            ST_DECODE: begin
                if (packet_valid) begin
                    if (!addr_valid) begin
                        state_d = ST_DROP;
                    end else if (empty_pad[data_in]) begin
                        state_d = ST_LFD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (empty_pad[sel_ch_q]) begin
                    state_d = ST_LFD;
                end else if (TO_EN && (to_cnt_q == '0)) begin
                    state_d      = ST_DROP;
                    timeout_fire = 1'b1;
                end
            end
            ST_LFD: state_d = ST_LD;
            ST_LD: begin
                if (fifo_full) begin
                    state_d = ST_FULL;
                end else if (!packet_valid) begin
                    state_d = ST_LP;
                end
            end
            ST_FULL: begin
                if (!fifo_full) begin
                    state_d = ST_LAF;
                end
            end
            ST_LAF: begin
                if (parity_done) begin
                    state_d = ST_DECODE;
                end else if (low_packet_valid) begin
                    state_d = ST_LP;
                end else begin
                    state_d = ST_LD;
                end
            end
            ST_LP:  state_d = ST_CPE;
            ST_CPE: state_d = fifo_full ? ST_FULL : ST_DECODE;
            ST_DROP: begin
                if (!packet_valid) begin
                    state_d = ST_DECODE;
                end
            end
            default: state_d = ST_DECODE;
        endcase

        if (srst_hit) begin
            state_d      = ST_DECODE;
            timeout_fire = 1'b0;
        end
    end

    // Channel latch, wait timer and timeout pulse
    always_comb begin
        sel_ch_d = sel_ch_q;
        if ((state_q == ST_DECODE) && packet_valid) begin
            sel_ch_d = data_in;
        end

        to_cnt_d = to_cnt_q;
        if (state_q != ST_WAIT) begin
            to_cnt_d = TO_LOAD;
        end else if (to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end

        timeout_err_d = timeout_fire;
    end

    // Moore output decode of the registered state
    always_comb begin
        write_enb_reg = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        drop_state    = 1'b0;
        case (state_q)
            ST_DECODE: detect_add = 1'b1;
            ST_WAIT:   busy       = 1'b1;
            ST_LFD: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            ST_LD: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_FULL: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            ST_LAF: begin
                laf_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_LP: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_CPE: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            ST_DROP: drop_state = 1'b1;
            default: detect_add = 1'b0;
        endcase
    end

    assign sel_ch      = sel_ch_q;
    assign timeout_err = timeout_err_q;

`ifdef ROUTER_FSM_DROP_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop_entry;

    // Count entries into ST_DROP, saturating; clear wins over increment
    always_comb begin
        drop_entry = (state_d == ST_DROP) && (state_q != ST_DROP);
        drop_cnt_d = drop_cnt_q;
        if (clr_stats) begin
            drop_cnt_d = '0;
        end else if (drop_entry && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop statistics register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed testbench for router_fsm_nch (NUM_CH=3, WAIT_TIMEOUT=8).
module tb_router_fsm_nch;

    logic       clk;
    logic       resetn;
    logic       packet_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_packet_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy, drop_state, timeout_err;
    logic [1:0] sel_ch;
`ifdef ROUTER_FSM_DROP_STATS_EN
    logic        clr_stats;
    logic [15:0] drop_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int wen_cnt;
    int rst_cnt;

    // {detect_add, lfd, ld, laf, full, rst_int, drop, busy, write_enb}
    localparam logic [8:0] S_DEC  = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] S_WAIT = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] S_LFD  = 9'b0_1_0_0_0_0_0_1_0;
    localparam logic [8:0] S_LD   = 9'b0_0_1_0_0_0_0_0_1;
    localparam logic [8:0] S_FULL = 9'b0_0_0_0_1_0_0_1_0;
    localparam logic [8:0] S_LAF  = 9'b0_0_0_1_0_0_0_1_1;
    localparam logic [8:0] S_LP   = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] S_CPE  = 9'b0_0_0_0_0_1_0_1_0;
    localparam logic [8:0] S_DROP = 9'b0_0_0_0_0_0_1_0_0;

    localparam logic [8:0] T1_SEQ [8] = '{S_LFD, S_LD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DEC};

    router_fsm_nch #(
        .NUM_CH(3),
        .ADDR_W(2),
        .WAIT_TIMEOUT(8),
        .TO_W(10)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .packet_valid(packet_valid),
        .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .soft_reset(soft_reset),
        .parity_done(parity_done),
        .low_packet_valid(low_packet_valid),
        .write_enb_reg(write_enb_reg),
        .detect_add(detect_add),
        .lfd_state(lfd_state),
        .ld_state(ld_state),
        .laf_state(laf_state),
        .full_state(full_state),
        .rst_int_reg(rst_int_reg),
        .busy(busy),
        .drop_state(drop_state),
        .sel_ch(sel_ch),
        .timeout_err(timeout_err)
`ifdef ROUTER_FSM_DROP_STATS_EN
        ,
        .clr_stats(clr_stats),
        .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] st_vec();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, drop_state, busy, write_enb_reg};
    endfunction

    task automatic check_st(input string tag, input logic [8:0] exp);
        check(tag, {23'd0, st_vec()}, {23'd0, exp});
    endtask

    initial begin
        resetn           = 1'b0;
        packet_valid     = 1'b0;
        data_in          = 2'd0;
        fifo_full        = 1'b0;
        fifo_empty       = 3'b111;
        soft_reset       = 3'b000;
        parity_done      = 1'b0;
        low_packet_valid = 1'b0;
`ifdef ROUTER_FSM_DROP_STATS_EN
        clr_stats        = 1'b0;
`endif
        step();
        step();
        check_st("reset_state", S_DEC);
        check("reset_sel_ch", {30'd0, sel_ch}, 32'd0);
        check("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
`ifdef ROUTER_FSM_DROP_STATS_EN
        check("reset_drop_count", {16'd0, drop_count}, 32'd0);
`endif
        resetn = 1'b1;
        step();
        check_st("idle_after_reset", S_DEC);

        // Normal packet to channel 2, four payload bytes
        wen_cnt      = 0;
        rst_cnt      = 0;
        packet_valid = 1'b1;
        data_in      = 2'd2;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) data_in = 2'd0;
            if (i == 5) packet_valid = 1'b0;
            step();
            check_st($sformatf("pkt1_state_%0d", i), T1_SEQ[i]);
            wen_cnt += int'(write_enb_reg);
            rst_cnt += int'(rst_int_reg);
            if (i == 0) check("pkt1_sel_ch", {30'd0, sel_ch}, 32'd2);
        end
        check("pkt1_wen_cycles", wen_cnt, 32'd5);
        check("pkt1_rst_int_cycles", rst_cnt, 32'd1);
        check("pkt1_sel_ch_hold", {30'd0, sel_ch}, 32'd2);

        // Invalid address 3: drop the whole packet
        packet_valid = 1'b1;
        data_in      = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_st($sformatf("drop_state_%0d", i), S_DROP);
        end
        packet_valid = 1'b0;
        step();
        check_st("drop_return", S_DEC);
`ifdef ROUTER_FSM_DROP_STATS_EN
        check("drop_count_1", {16'd0, drop_count}, 32'd1);
`endif

        // Wait timeout on channel 1
        packet_valid = 1'b1;
        data_in      = 2'd1;
        fifo_empty   = 3'b101;
        for (int i = 0; i < 8; i++) begin
            step();
            check_st($sformatf("to_wait_%0d", i), S_WAIT);
            check($sformatf("to_no_err_%0d", i), {31'd0, timeout_err}, 32'd0);
        end
        step();
        check_st("to_drop", S_DROP);
        check("to_err_pulse", {31'd0, timeout_err}, 32'd1);
        packet_valid = 1'b0;
        step();
        check_st("to_return", S_DEC);
        check("to_err_once", {31'd0, timeout_err}, 32'd0);
`ifdef ROUTER_FSM_DROP_STATS_EN
        check("drop_count_2", {16'd0, drop_count}, 32'd2);
`endif

        // Empty arrives on the timeout cycle: empty wins
        packet_valid = 1'b1;
        data_in      = 2'd1;
        for (int i = 0; i < 8; i++) step();
        check_st("race_wait_last", S_WAIT);
        fifo_empty = 3'b111;
        step();
        check_st("race_lfd", S_LFD);
        check("race_no_err", {31'd0, timeout_err}, 32'd0);
        step();
        check_st("race_ld", S_LD);
        packet_valid = 1'b0;
        step();
        check_st("race_lp", S_LP);
        step();
        check_st("race_cpe", S_CPE);
        step();
        check_st("race_dec", S_DEC);
        check("race_no_err_after", {31'd0, timeout_err}, 32'd0);

        // FIFO-full stall then resume with low_packet_valid
        packet_valid = 1'b1;
        data_in      = 2'd0;
        step();
        check_st("full_lfd", S_LFD);
        step();
        check_st("full_ld", S_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_st($sformatf("full_stall_%0d", i), S_FULL);
        end
        fifo_full        = 1'b0;
        packet_valid     = 1'b0;
        low_packet_valid = 1'b1;
        step();
        check_st("full_laf", S_LAF);
        step();
        check_st("full_lp", S_LP);
        low_packet_valid = 1'b0;
        step();
        check_st("full_cpe", S_CPE);
        step();
        check_st("full_dec", S_DEC);

        // Full stall ending with parity_done: straight back to decode
        packet_valid = 1'b1;
        data_in      = 2'd0;
        step();
        step();
        fifo_full = 1'b1;
        step();
        check_st("pd_full", S_FULL);
        fifo_full   = 1'b0;
        parity_done = 1'b1;
        step();
        check_st("pd_laf", S_LAF);
        step();
        check_st("pd_dec", S_DEC);
        parity_done  = 1'b0;
        packet_valid = 1'b0;
        step();

        // Soft reset: other channel ignored, selected channel aborts
        packet_valid = 1'b1;
        data_in      = 2'd1;
        step();
        step();
        check_st("srst_ld", S_LD);
        check("srst_sel_ch", {30'd0, sel_ch}, 32'd1);
        soft_reset = 3'b100;
        step();
        check_st("srst_other_ignored", S_LD);
        soft_reset = 3'b010;
        step();
        check_st("srst_selected", S_DEC);
        soft_reset   = 3'b000;
        packet_valid = 1'b0;
        step();
        check_st("srst_idle", S_DEC);

`ifdef ROUTER_FSM_DROP_STATS_EN
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("drop_count_clr", {16'd0, drop_count}, 32'd0);
`endif

        // Asynchronous reset in the middle of LOAD_DATA
        packet_valid = 1'b1;
        data_in      = 2'd2;
        step();
        step();
        check_st("areset_pre_ld", S_LD);
        #2;
        resetn = 1'b0;
        #1;
        check("areset_detect_add", {31'd0, detect_add}, 32'd1);
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_sel_ch", {30'd0, sel_ch}, 32'd0);
        check_st("areset_state", S_DEC);
        packet_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        check_st("areset_release", S_DEC);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
